// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the data-memory port of a pipelined core.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   if_req/if_addr        fetch read request and address
//   if_rdata/if_ack       fetched word, one-cycle completion pulse
//   dm_req/dm_we          data request, 1 = write
//   dm_addr/dm_wdata      data address and write data
//   dm_rdata/dm_ack       loaded word, one-cycle completion pulse
//   mem_req/mem_we        request and write enable to the shared memory
//   mem_addr/mem_wdata    memory address/write data (from grant latches)
//   mem_rdata/mem_ready   memory read data and completion strobe
//   stallF/stallM         pipeline stalls: request pending and not acked
//   err                   sticky flag: a memory access timed out
//   dbg_state_o           current FSM state (0 IDLE, 1 FETCH, 2 DATA)
//
// Handshake: a port holds req until its ack pulse. mem_req stays high with
// mem_addr/mem_wdata frozen until the memory returns mem_ready, or until
// the wait counter runs out; mem_ready is only meaningful while mem_req=1.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stallF,
    output logic          stallM,
    output logic          err,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_e;

    // Last wait-counter value before giving up on the memory.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                // A port whose ack is high this cycle is still showing the
                // request that just completed, so it is not re-granted until
                // it requests again after the ack.
                if (dm_req && !dm_ack_q) begin
                    state_d = S_DATA;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    cnt_d   = 8'd0;
                end else if (if_req && !if_ack_q) begin
                    state_d = S_FETCH;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    cnt_d   = 8'd0;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                    if (state_q == S_FETCH) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Timeout: release the requester with its old data.
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        if (state_q == S_FETCH) begin
                            if_ack_d = 1'b1;
                        end else begin
                            dm_ack_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 8'd0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            err_q      <= err_d;
        end
    end

    assign mem_req     = (state_q != S_IDLE);
    assign mem_we      = (state_q == S_DATA) && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ack      = if_ack_q;
    assign dm_ack      = dm_ack_q;
    assign err         = err_q;
    // Combinational so the stalls track the requests even during reset.
    assign stallF      = if_req & ~if_ack_q;
    assign stallM      = dm_req & ~dm_ack_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, with a
// scoreboard of expected acks and expected memory operations.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stallF;
    logic          stallM;
    logic          err;
    logic [1:0]    dbg_state;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stallF(stallF), .stallM(stallM), .err(err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW:0]    if_exp_q[$];   // {err, if_rdata} at each if_ack
    logic [DW:0]    dm_exp_q[$];   // {err, dm_rdata} at each dm_ack
    logic [AW+DW:0] op_exp_q[$];   // {we, addr, wdata} per memory grant
    int             wait_q[$];     // memory wait cycles per grant

    logic [DW-1:0] mem_arr[64];    // the memory seen by the responder
    logic [DW-1:0] ref_mem[64];    // reference model's view of memory
    logic [DW-1:0] ref_if_rdata;
    logic [DW-1:0] ref_dm_rdata;
    logic          ref_err;
    bit            force_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Cycles from request to observed ack for w memory wait cycles.
    function automatic int lat(input int w);
        return ((w + 1 < TO) ? w + 1 : TO) + 1;
    endfunction

    // ---------------- monitor: acks, stalls ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("stallF", stallF, if_req & ~if_ack);
            check("stallM", stallM, dm_req & ~dm_ack);
            if (!mem_req) check("mem_we_idle", mem_we, 1'b0);
            if (if_ack) begin
                if (if_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL if_ack_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    check("if_ack_data", {err, if_rdata}, if_exp_q.pop_front());
                end
            end
            if (dm_ack) begin
                if (dm_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL dm_ack_unexpected: got 1 expected 0 at %0t", $time);
                end else begin
                    check("dm_ack_data", {err, dm_rdata}, dm_exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        bit             busy;
        int             rcnt;
        int             rwait;
        logic [AW+DW:0] held;
        busy      = 1'b0;
        rcnt      = 0;
        rwait     = 0;
        held      = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom();
            if (!mem_req) begin
                busy = 1'b0;
                // Strobes while idle must be ignored by the arbiter.
                if (force_ready || ($urandom_range(0, 1) == 1)) mem_ready = 1'b1;
            end else begin
                if (!busy) begin
                    busy  = 1'b1;
                    rcnt  = 0;
                    rwait = (wait_q.size() != 0) ? wait_q.pop_front() : 1000;
                    held  = {mem_we, mem_addr, mem_wdata};
                    if (op_exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL mem_grant_unexpected: got addr 0x%0h expected none", mem_addr);
                    end else begin
                        check("mem_op", {mem_we, mem_addr, mem_we ? mem_wdata : {DW{1'b0}}},
                              op_exp_q.pop_front());
                    end
                end else begin
                    check("mem_hold", {mem_we, mem_addr, mem_wdata}, held);
                end
                if (rcnt == rwait) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem_arr[mem_addr[7:2]] = mem_wdata;
                    else        mem_rdata = mem_arr[mem_addr[7:2]];
                end
                rcnt++;
            end
        end
    end

    // ---------------- driver ----------------
    // Issues a fetch, a data access, or both at once; the model resolves the
    // order (data first), the memory effect and the timeout outcome.
    task automatic run_txn(input bit use_if, input bit use_dm, input bit dwe,
                           input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                           input logic [DW-1:0] dwdata, input int iw, input int dw,
                           input bit drop_dm);
        int exp_d;
        int exp_i;
        int t;
        bit got_i;
        bit got_d;
        exp_d = 0;
        exp_i = 0;
        if (use_dm) begin
            op_exp_q.push_back({dwe, daddr, dwe ? dwdata : {DW{1'b0}}});
            wait_q.push_back(dw);
            if (dw >= TO)  ref_err = 1'b1;
            else if (dwe)  ref_mem[daddr[7:2]] = dwdata;
            else           ref_dm_rdata = ref_mem[daddr[7:2]];
            dm_exp_q.push_back({ref_err, ref_dm_rdata});
            exp_d = lat(dw);
        end
        if (use_if) begin
            op_exp_q.push_back({1'b0, iaddr, {DW{1'b0}}});
            wait_q.push_back(iw);
            if (iw >= TO) ref_err = 1'b1;
            else          ref_if_rdata = ref_mem[iaddr[7:2]];
            if_exp_q.push_back({ref_err, ref_if_rdata});
            exp_i = exp_d + lat(iw);
        end
        if_req   = use_if;
        if_addr  = iaddr;
        dm_req   = use_dm;
        dm_we    = dwe;
        dm_addr  = daddr;
        dm_wdata = dwdata;
        got_i = !use_if;
        got_d = !use_dm;
        t = 0;
        while ((!got_i || !got_d) && t < 60) begin
            step();
            t++;
            if (t == 1) begin
                // The grant is latched; live inputs may now change freely.
                if (use_dm) begin
                    dm_addr  = $urandom();
                    dm_wdata = $urandom();
                    dm_we    = $urandom_range(0, 1);
                    if (drop_dm) dm_req = 1'b0;
                end else begin
                    if_addr = $urandom();
                end
            end
            if (!got_d && dm_ack) begin
                got_d = 1'b1;
                check("dm_latency", t, exp_d);
                dm_req = 1'b0;
            end
            if (!got_i && if_ack) begin
                got_i = 1'b1;
                check("if_latency", t, exp_i);
                if_req = 1'b0;
            end
        end
        if (!got_i || !got_d) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_wait: got no ack after %0d cycles expected ack", t);
            if_req = 1'b0;
            dm_req = 1'b0;
        end
        repeat ($urandom_range(1, 3)) step();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 63));
        return a << 2;
    endfunction

    task automatic random_txns(input int n);
        for (int i = 0; i < n; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)), rand_addr(),
                    rand_addr(), $urandom(), $urandom_range(0, 4),
                    $urandom_range(0, 4), (kind == 1) && ($urandom_range(0, 3) == 0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [AW-1:0] a;
        reset    = 1'b0;
        if_req   = 1'b1;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = $urandom();
            ref_mem[i] = mem_arr[i];
        end
        ref_if_rdata = '0;
        ref_dm_rdata = '0;
        ref_err      = 1'b0;

        // Reset state; stalls follow the requests during reset.
        repeat (3) step();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_outputs", {mem_we, if_ack, dm_ack, err}, 4'b0);
        check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        check("rst_latches", {mem_addr, mem_wdata}, 64'd0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_stallF", stallF, 1'b1);
        if_req = 1'b0;
        step();
        reset = 1'b1;
        repeat (2) step();

        // Fetch of 0x40 completing after one cycle.
        mem_arr[16] = 32'h2002000A;
        ref_mem[16] = 32'h2002000A;
        run_txn(1'b1, 1'b0, 1'b0, 32'h40, '0, '0, 0, 0, 1'b0);
        check("fetch_rdata", if_rdata, 32'h2002000A);

        // Contention: the write goes first, then the fetch.
        run_txn(1'b1, 1'b1, 1'b1, 32'h44, 32'h80, 32'h5, 0, 0, 1'b0);

        // Load with three wait cycles.
        a = 32'h0C;
        mem_arr[3] = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;
        run_txn(1'b0, 1'b1, 1'b0, '0, a, '0, 0, 3, 1'b0);
        check("load_rdata", dm_rdata, 32'hDEADBEEF);

        // Read back the earlier write.
        run_txn(1'b0, 1'b1, 1'b0, '0, 32'h80, '0, 0, 1, 1'b0);
        check("readback", dm_rdata, 32'h5);

        // Requester drops dm_req right after the grant.
        run_txn(1'b0, 1'b1, 1'b0, '0, 32'h40, '0, 0, 2, 1'b1);

        random_txns(20);

        // Timeout: memory never answers.
        run_txn(1'b0, 1'b1, 1'b0, '0, rand_addr(), '0, 0, 99, 1'b0);
        check("timeout_err", err, 1'b1);
        check("timeout_state", dbg_state, 2'd0);
        step();
        check("err_sticky", err, 1'b1);

        random_txns(20);

        // Reset while a data access is outstanding.
        op_exp_q.push_back({1'b0, 32'h20, {DW{1'b0}}});
        wait_q.push_back(1000);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h20;
        repeat (2) step();
        check("pre_rst_mem_req", mem_req, 1'b1);
        reset = 1'b0;
        step();
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_ack_err", {if_ack, dm_ack, err}, 3'b0);
        check("midrst_stallM", stallM, 1'b1);
        check("midrst_rdata", {if_rdata, dm_rdata}, 64'd0);
        reset        = 1'b1;
        dm_req       = 1'b0;
        ref_err      = 1'b0;
        ref_if_rdata = '0;
        ref_dm_rdata = '0;
        force_ready  = 1'b1;
        repeat (3) step();
        force_ready  = 1'b0;
        check("postrst_state", dbg_state, 2'd0);

        random_txns(10);

        repeat (4) step();
        check("if_q_empty", if_exp_q.size(), 0);
        check("dm_q_empty", dm_exp_q.size(), 0);
        check("op_q_empty", op_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters:
- AW, default 32, address width.
- DW, default 32, data width.
- TIMEOUT, default 15, maximum wait cycles for mem_ready (range 1..255).

REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- dm_req  in  1  data-memory request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  loaded word.
- dm_ack  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  request to the shared single-port memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completion strobe.
- stallF  out  1  fetch-stage stall, OR-ed with the hazard-unit stall.
- stallM  out  1  memory-stage stall.
- err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement an FSM with states IDLE, FETCH, DATA.
REQ-004 In IDLE, if dm_req=1 SHALL go to DATA, else if if_req=1 SHALL go to FETCH, else SHALL stay in IDLE. Data has fixed priority because it is the older instruction.
REQ-005 On leaving IDLE SHALL latch address, we, and wdata of the granted requester. Memory outputs SHALL come from these latches, never from live inputs.
REQ-006 mem_req SHALL be 1 in FETCH and DATA and 0 in IDLE. mem_we SHALL be 1 only in DATA with latched we=1. mem_addr/mem_wdata SHALL be held stable while mem_req=1.
REQ-007 In FETCH/DATA, when mem_ready=1:
- SHALL register mem_rdata into if_rdata or dm_rdata (write: dm_rdata unchanged).
- SHALL pulse the matching ack for exactly the next cycle.
- SHALL return to IDLE.
REQ-008 Minimum latency: request seen in IDLE at cycle N, mem_ready at cycle N+1 gives ack at cycle N+2.
REQ-009 if_rdata/dm_rdata SHALL hold their value until the next completion of the same port.
REQ-010 Requester dropping req mid-transaction SHALL NOT abort it. The transaction completes and ack still pulses.
REQ-011 In the cycle an ack is high, the FSM is in IDLE and SHALL re-arbitrate normally. A requester still holding req SHALL be re-granted only if it asserts req again after the ack.
REQ-012 Stall outputs:
- stallF = if_req & ~if_ack.
- stallM = dm_req & ~dm_ack.
REQ-013 A wait counter (8 bits) SHALL:
- clear on entering FETCH/DATA;
- increment each cycle in those states with mem_ready=0.
REQ-014 When the counter reaches TIMEOUT with mem_ready=0, SHALL:
- set err=1;
- go to IDLE;
- pulse the matching ack;
- leave rdata unchanged.
err SHALL stay set until reset.
REQ-015 mem_ready in IDLE SHALL be ignored.
REQ-016 Simultaneous if_req and dm_req in IDLE SHALL grant data. Fetch SHALL be served in the first IDLE cycle with no dm_req.

Reset
REQ-017 With reset=0 at a rising edge, SHALL set:
- state = IDLE;
- mem_req, mem_we, if_ack, dm_ack, err = 0;
- if_rdata, dm_rdata, latches, counter = 0.
REQ-018 Reset mid-transaction SHALL abandon it with no ack. Any late mem_ready SHALL be ignored per REQ-015.
REQ-019 stallF/stallM SHALL follow REQ-012 combinationally even during reset. Acks are 0 during reset, so the stalls follow the requests.

Verification
REQ-020 Fetch: if_req=1, if_addr=0x40; mem_ready=1 one cycle after mem_req with mem_rdata=0x2002000A -> mem_addr=0x40, mem_we=0, if_ack pulses once, if_rdata=0x2002000A, stallF low in the ack cycle.
REQ-021 Contention: if_req=dm_req=1 simultaneously, dm_we=1, dm_addr=0x80, dm_wdata=0x5 -> write granted first (mem_we=1, mem_addr=0x80), dm_ack precedes if_ack, stallF held high throughout.
REQ-022 Load with 3 wait cycles, mem_rdata=0xDEADBEEF -> mem_addr held constant 4 cycles, dm_ack one cycle after mem_ready, dm_rdata=0xDEADBEEF, stallM high until ack.
REQ-023 Timeout, TIMEOUT=4, mem_ready never asserted -> err=1 after 4 wait cycles, dm_ack pulses, FSM in IDLE, dm_rdata unchanged, err stays 1.
REQ-024 reset=0 during the DATA state -> next cycle mem_req=0, no ack, err=0; a mem_ready after reset is released causes no ack.
REQ-025 dm_req dropped one cycle after grant -> mem_req stays 1 until mem_ready, dm_ack still pulses.
